sim_run_ctrl: RTL

- Parametrised run controller for CPU simulation harnesses. Successor to the free-running clock/reset test fixture.
- Holds the core in reset for a programmed number of cycles, then releases it.
- Monitors up to NUM_PORTS retirement (writeback) ports and counts cycles and retired instructions.
- Ends the run with a pass, hang or timeout verdict. Sits between the harness clock/reset and the TopLevel core under test.

---
 rtl/sim_run_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sim_run_ctrl.sv
// Run controller for CPU simulation harnesses: sequences core reset, watches retirement
// ports, counts cycles/instructions and ends the run with a pass, hang or timeout verdict.
module sim_run_ctrl #(
    parameter int unsigned     NUM_PORTS      = 2,
    parameter int unsigned     PC_W           = 32,
    parameter int unsigned     CNT_W          = 32,
    parameter int unsigned     RESET_CYCLES   = 16,
    parameter int unsigned     TIMEOUT_CYCLES = 1000000,
    parameter int unsigned     STALL_LIMIT    = 4096,
    parameter logic [PC_W-1:0] END_PC         = 32'hBFC00100
) (
    input  logic                      Clk,
    input  logic                      Clr,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NUM_PORTS-1:0]      wb_valid,
    input  logic [NUM_PORTS*PC_W-1:0] wb_pc,
    output logic                      core_rst_n,
    output logic                      running,
    output logic                      done,
    output logic                      pass,
    output logic                      hang,
    output logic                      timeout,
    output logic [CNT_W-1:0]          cycle_count,
    output logic [CNT_W-1:0]          retire_count,
    output logic [PC_W-1:0]           last_pc
);

    localparam int unsigned      PopW        = $clog2(NUM_PORTS + 1);
    localparam int unsigned      RstW        = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RstW-1:0]  RstLast     = RstW'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] StallLast   = CNT_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReset, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic             core_rst_n_q, core_rst_n_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             hang_q, hang_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [PC_W-1:0]  last_pc_q, last_pc_d;
    logic [RstW-1:0]  rst_cnt_q, rst_cnt_d;

    logic             any_valid;
    logic             pass_hit;
    logic             hang_hit;
    logic             to_hit;
    logic [PopW-1:0]  pop;
    logic [PC_W-1:0]  pc_sel;
    logic [CNT_W:0]   ret_sum;
    logic [CNT_W-1:0] ret_inc;
    logic [CNT_W-1:0] cyc_inc;

    // Later ports overwrite pc_sel, so the highest-index valid port wins.
    always_comb begin
        any_valid = 1'b0;
        pass_hit  = 1'b0;
        pop       = '0;
        pc_sel    = last_pc_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wb_valid[i]) begin
                any_valid = 1'b1;
                pop       = pop + PopW'(1);
                pc_sel    = wb_pc[i*PC_W +: PC_W];
                if (wb_pc[i*PC_W +: PC_W] == END_PC) begin
                    pass_hit = 1'b1;
                end
            end
        end
        hang_hit = !any_valid && (stall_q == StallLast);
        to_hit   = (cycle_q == TimeoutLast);
        ret_sum  = {1'b0, retire_q} + (CNT_W + 1)'(pop);
        ret_inc  = ret_sum[CNT_W] ? '1 : ret_sum[CNT_W-1:0];
        cyc_inc  = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (!Clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StReset;
            StReset: begin
                if (abort) begin
                    state_d = StDone;
                end else if (rst_cnt_q == RstLast) begin
                    state_d = StRun;
                end
            end
            StRun:   if (abort || pass_hit || hang_hit || to_hit) state_d = StDone;
            StDone:  if (start) state_d = StReset;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cycle_d   = cycle_q;
        retire_d  = retire_q;
        stall_d   = stall_q;
        last_pc_d = last_pc_q;
        rst_cnt_d = rst_cnt_q;
        pass_d    = pass_q;
        hang_d    = hang_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (state_d == StReset) begin
                    cycle_d   = '0;
                    retire_d  = '0;
                    stall_d   = '0;
                    last_pc_d = '0;
                    rst_cnt_d = '0;
                    pass_d    = 1'b0;
                    hang_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            StReset: rst_cnt_d = rst_cnt_q + RstW'(1);
            StRun: begin
                cycle_d   = cyc_inc;
                retire_d  = ret_inc;
                last_pc_d = pc_sel;
                stall_d   = any_valid ? '0 : stall_q + CNT_W'(1);
                // abort exits with every verdict flag left clear.
                if (!abort) begin
                    pass_d    = pass_hit;
                    hang_d    = !pass_hit && hang_hit;
                    timeout_d = !pass_hit && !hang_hit && to_hit;
                end
            end
            default: ;
        endcase
        core_rst_n_d = (state_d == StRun) || (state_d == StDone);
        running_d    = (state_d == StRun);
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge Clk) begin
        if (!Clr) begin
            core_rst_n_q <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            hang_q       <= 1'b0;
            timeout_q    <= 1'b0;
            cycle_q      <= '0;
            retire_q     <= '0;
            stall_q      <= '0;
            last_pc_q    <= '0;
            rst_cnt_q    <= '0;
        end else begin
            core_rst_n_q <= core_rst_n_d;
            running_q    <= running_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            hang_q       <= hang_d;
            timeout_q    <= timeout_d;
            cycle_q      <= cycle_d;
            retire_q     <= retire_d;
            stall_q      <= stall_d;
            last_pc_q    <= last_pc_d;
            rst_cnt_q    <= rst_cnt_d;
        end
    end

    assign core_rst_n   = core_rst_n_q;
    assign running      = running_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign hang         = hang_q;
    assign timeout      = timeout_q;
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;
    assign last_pc      = last_pc_q;

endmodule
